// File: rtl/uart_block_rx.sv
// UART receive path: 8N1 deserialiser plus a line assembler that emits one
// SHA-256-padded 512-bit message block per CR/LF-terminated line.
//
// state      | meaning
// B_IDLE     | waiting for a synced 1->0 edge on RXD
// B_START    | half-bit wait, then confirm start bit (1 = glitch)
// B_DATA     | eight LSB-first samples, one bit period apart
// B_STOP     | stop-bit sample; good byte or framing error
// A_COLLECT  | storing bytes of the current line
// A_DISCARD  | line overflowed; dropping bytes until a terminator
// A_HOLD     | block presented, waiting for block_ack
module uart_block_rx #(
   parameter int CLK_FREQ = 60000000,
   parameter int BAUD     = 115200
) (
   input  logic         CLK,
   input  logic         reset,
   input  logic         RXD,
   output logic [0:511] block,
   output logic         block_valid,
   input  logic         block_ack,
   output logic [5:0]   byte_len,
   output logic [7:0]   rx_data,
   output logic         rx_strobe,
   output logic         frame_err,
   output logic         overflow
);
   localparam int CPB  = CLK_FREQ / BAUD;
   localparam int HALF = CPB / 2;
   localparam int CW   = $clog2(CPB);
   localparam int MAXB = 55;

   typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_st_t;
   typedef enum logic [1:0] {A_COLLECT, A_DISCARD, A_HOLD} asm_st_t;

   logic          rxd_meta_q, rxd_sync_q, rxd_prev_q;
   bit_st_t       bst_q, bst_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    rx_data_q, rx_data_d;
   logic          rx_strobe_q, rx_strobe_d;
   logic          frame_err_q, frame_err_d;

   asm_st_t       ast_q, ast_d;
   logic [5:0]    count_q, count_d;
   logic [7:0]    mem_q [MAXB];
   logic [7:0]    mem_d [MAXB];
   logic [0:511]  block_q, block_d, blk_built;
   logic          block_valid_q, block_valid_d;
   logic [5:0]    byte_len_q, byte_len_d;
   logic          overflow_q, overflow_d;
   logic          is_term;

   always_comb begin
      bst_d       = bst_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_strobe_d = 1'b0;
      frame_err_d = 1'b0;
      case (bst_q)
         B_IDLE: begin
            if (!rxd_sync_q && rxd_prev_q) begin
               bst_d = B_START;
               cnt_d = CW'(HALF - 1);
            end
         end
         B_START: begin
            if (cnt_q == '0) begin
               if (rxd_sync_q) begin
                  bst_d = B_IDLE;
               end else begin
                  bst_d     = B_DATA;
                  cnt_d     = CW'(CPB - 1);
                  bit_idx_d = 3'd0;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         B_DATA: begin
            if (cnt_q == '0) begin
               shift_d = {rxd_sync_q, shift_q[7:1]};
               cnt_d   = CW'(CPB - 1);
               if (bit_idx_q == 3'd7) bst_d = B_STOP;
               else bit_idx_d = bit_idx_q + 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            if (cnt_q == '0) begin
               bst_d = B_IDLE;
               if (rxd_sync_q) begin
                  rx_data_d   = shift_q;
                  rx_strobe_d = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         rxd_meta_q  <= 1'b1;
         rxd_sync_q  <= 1'b1;
         rxd_prev_q  <= 1'b1;
         bst_q       <= B_IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= 3'd0;
         shift_q     <= 8'h00;
         rx_data_q   <= 8'h00;
         rx_strobe_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         rxd_meta_q  <= RXD;
         rxd_sync_q  <= rxd_meta_q;
         rxd_prev_q  <= rxd_sync_q;
         bst_q       <= bst_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_strobe_q <= rx_strobe_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Padding is built from storage at terminator time so stale bytes never leak.
   always_comb begin
      blk_built = '0;
      for (int i = 0; i < MAXB; i++)
         if (6'(i) < count_q) blk_built[8*i +: 8] = mem_q[i];
      for (int i = 0; i <= MAXB; i++)
         if (6'(i) == count_q) blk_built[8*i +: 8] = 8'h80;
      blk_built[448 +: 64] = {55'b0, count_q, 3'b0};
   end

   assign is_term = (rx_data_q == 8'h0D) || (rx_data_q == 8'h0A);

   always_comb begin
      ast_d         = ast_q;
      count_d       = count_q;
      mem_d         = mem_q;
      block_d       = block_q;
      block_valid_d = block_valid_q;
      byte_len_d    = byte_len_q;
      overflow_d    = 1'b0;
      case (ast_q)
         A_COLLECT: begin
            if (rx_strobe_q) begin
               if (is_term) begin
                  if (count_q != 6'd0) begin
                     block_d       = blk_built;
                     block_valid_d = 1'b1;
                     byte_len_d    = count_q;
                     ast_d         = A_HOLD;
                  end
               end else if (count_q == 6'(MAXB)) begin
                  overflow_d = 1'b1;
                  ast_d      = A_DISCARD;
               end else begin
                  mem_d[count_q] = rx_data_q;
                  count_d        = count_q + 1'b1;
               end
            end
         end
         A_DISCARD: begin
            if (rx_strobe_q && is_term) begin
               ast_d   = A_COLLECT;
               count_d = 6'd0;
            end
         end
         A_HOLD: begin
            if (rx_strobe_q && !is_term) overflow_d = 1'b1;
            if (block_ack) begin
               block_valid_d = 1'b0;
               ast_d         = A_COLLECT;
               count_d       = 6'd0;
            end
         end
         default: ast_d = A_COLLECT;
      endcase
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         ast_q         <= A_COLLECT;
         count_q       <= 6'd0;
         for (int i = 0; i < MAXB; i++) mem_q[i] <= 8'h00;
         block_q       <= '0;
         block_valid_q <= 1'b0;
         byte_len_q    <= 6'd0;
         overflow_q    <= 1'b0;
      end else begin
         ast_q         <= ast_d;
         count_q       <= count_d;
         mem_q         <= mem_d;
         block_q       <= block_d;
         block_valid_q <= block_valid_d;
         byte_len_q    <= byte_len_d;
         overflow_q    <= overflow_d;
      end
   end

   assign block       = block_q;
   assign block_valid = block_valid_q;
   assign byte_len    = byte_len_q;
   assign rx_data     = rx_data_q;
   assign rx_strobe   = rx_strobe_q;
   assign frame_err   = frame_err_q;
   assign overflow    = overflow_q;
endmodule
